// File: rtl/eth_type_extract.sv
// -----------------------------------------------------------------------------
// eth_type_extract
//
// Sits in front of the TSN NIC descriptor generator. The 9-bit per-port byte
// stream is delayed by a fixed pipeline while the EtherType is captured from
// the frame header. Because the header has been parsed before the head byte
// leaves the pipeline, the EtherType and the standard/TSN flag are already
// valid in the cycle the head appears on the output. Frames that end, or
// stall, before their EtherType has been seen (runts) are removed from the
// stream and counted.
//
// Optional feature (macro ETH_TYPE_VLAN_EN):
//   When defined, a frame whose bytes 12-13 are 16'h8100 takes its EtherType
//   from bytes 16-17 instead. Such a frame must reach byte 17 to be kept, and
//   the pipeline depth becomes 18 regardless of DELAY_CYCLES.
//   When undefined, the EtherType always comes from bytes 12-13 and the depth
//   is DELAY_CYCLES.
//
// Parameters:
//   DELAY_CYCLES  input-to-output latency in cycles (>= 14)
//   TSN_ETH_TYPE  EtherType that marks a mapped TSN frame
//
// Ports:
//   i_clk                      clock
//   i_rst_n                    asynchronous active-low reset
//   iv_data[8:0]               byte stream; [8] flags head and tail bytes
//   i_data_wr                  byte valid, contiguous within a frame
//   ov_data[8:0]               delayed byte stream (zero when suppressed)
//   o_data_wr                  delayed byte valid
//   ov_eth_type[15:0]          EtherType of the frame on the output
//   o_standardpkt_tsnpkt_flag  1 = standard frame, 0 = TSN mapped frame
//   ov_runt_discard_cnt[31:0]  number of dropped runt/truncated frames
//   ov_in_state[1:0]           input capture FSM state (debug)
// -----------------------------------------------------------------------------
module eth_type_extract #(
    parameter int          DELAY_CYCLES = 14,
    parameter logic [15:0] TSN_ETH_TYPE = 16'h1800
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [8:0]  iv_data,
    input  logic        i_data_wr,
    output logic [8:0]  ov_data,
    output logic        o_data_wr,
    output logic [15:0] ov_eth_type,
    output logic        o_standardpkt_tsnpkt_flag,
    output logic [31:0] ov_runt_discard_cnt,
    output logic [1:0]  ov_in_state
);

`ifdef ETH_TYPE_VLAN_EN
    localparam bit VLAN_EN = 1'b1;
    localparam int DEPTH   = 18;
`else
    localparam bit VLAN_EN = 1'b0;
    localparam int DEPTH   = DELAY_CYCLES;
`endif

    // The output register is the last pipeline stage, so the delay line
    // itself holds DEPTH-1 stages and the output decision looks at the last.
    localparam int TAP = DEPTH - 2;

    localparam logic [15:0] VLAN_TPID = 16'h8100;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        HDR_S  = 2'd1,
        BODY_S = 2'd2
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE_S = 2'd0,
        OUT_PASS_S = 2'd1,
        OUT_DROP_S = 2'd2
    } out_state_t;

    // -------------------------------------------------------------------------
    // Delay line
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi <= TAP; gi++) begin : g_dl
            logic       wr_reg;
            logic [8:0] data_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        wr_reg   <= 1'b0;
                        data_reg <= 9'd0;
                    end else begin
                        wr_reg   <= i_data_wr;
                        data_reg <= i_data_wr ? iv_data : 9'd0;
                    end
                end
            end else begin : g_next
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        wr_reg   <= 1'b0;
                        data_reg <= 9'd0;
                    end else begin
                        wr_reg   <= g_dl[gi-1].wr_reg;
                        data_reg <= g_dl[gi-1].data_reg;
                    end
                end
            end
        end
    endgenerate

    logic       tap_wr;
    logic [8:0] tap_data;
    assign tap_wr   = g_dl[TAP].wr_reg;
    assign tap_data = g_dl[TAP].data_reg;

    // -------------------------------------------------------------------------
    // Input capture FSM
    //
    // A flagged byte only starts a frame if no stray (unflagged, out-of-frame)
    // bytes precede it. After a frame is cut short by a gap, its remaining
    // bytes arrive as strays and its tail would otherwise be mistaken for a
    // new head. The output side applies the same rule to the delayed stream,
    // so both sides agree on which bytes are heads.
    // -------------------------------------------------------------------------
    in_state_t  in_state_reg,  in_state_next;
    logic [4:0] byte_cnt_reg,  byte_cnt_next;
    logic [7:0] type_hi_reg,   type_hi_next;
    logic       vlan_reg,      vlan_next;
    logic       in_stray_reg,  in_stray_next;
    logic       commit;
    logic       fifo_push;
    logic       push_runt;
    logic [15:0] push_type;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_state_reg <= IDLE_S;
            byte_cnt_reg <= 5'd0;
            type_hi_reg  <= 8'd0;
            vlan_reg     <= 1'b0;
            in_stray_reg <= 1'b0;
        end else begin
            in_state_reg <= in_state_next;
            byte_cnt_reg <= byte_cnt_next;
            type_hi_reg  <= type_hi_next;
            vlan_reg     <= vlan_next;
            in_stray_reg <= in_stray_next;
        end
    end

    always_comb begin
        in_state_next = in_state_reg;
        byte_cnt_next = byte_cnt_reg;
        type_hi_next  = type_hi_reg;
        vlan_next     = vlan_reg;
        in_stray_next = in_stray_reg;
        commit        = 1'b0;
        fifo_push     = 1'b0;
        push_runt     = 1'b0;
        push_type     = 16'h0000;

        case (in_state_reg)
            IDLE_S: begin
                if (i_data_wr) begin
                    if (iv_data[8]) begin
                        if (in_stray_reg) begin
                            // tail of a frame that was cut short
                            in_stray_next = 1'b0;
                        end else begin
                            in_state_next = HDR_S;
                            byte_cnt_next = 5'd1;
                            vlan_next     = 1'b0;
                        end
                    end else begin
                        in_stray_next = 1'b1;
                    end
                end
            end

            HDR_S: begin
                if (!i_data_wr) begin
                    fifo_push     = 1'b1;
                    push_runt     = 1'b1;
                    in_state_next = IDLE_S;
                end else begin
                    byte_cnt_next = byte_cnt_reg + 5'd1;
                    if (byte_cnt_reg == 5'd12 || (vlan_reg && byte_cnt_reg == 5'd16)) begin
                        type_hi_next = iv_data[7:0];
                    end
                    if (byte_cnt_reg == 5'd13 && !vlan_reg) begin
                        if (VLAN_EN && {type_hi_reg, iv_data[7:0]} == VLAN_TPID) begin
                            vlan_next = 1'b1;
                        end else begin
                            commit = 1'b1;
                        end
                    end
                    if (vlan_reg && byte_cnt_reg == 5'd17) begin
                        commit = 1'b1;
                    end

                    if (commit) begin
                        fifo_push     = 1'b1;
                        push_type     = {type_hi_reg, iv_data[7:0]};
                        in_state_next = iv_data[8] ? IDLE_S : BODY_S;
                    end else if (iv_data[8]) begin
                        fifo_push     = 1'b1;
                        push_runt     = 1'b1;
                        in_state_next = IDLE_S;
                    end
                end
            end

            BODY_S: begin
                if (!i_data_wr || iv_data[8]) begin
                    in_state_next = IDLE_S;
                end
            end

            default: begin
                in_state_next = IDLE_S;
            end
        endcase
    end

    assign ov_in_state = in_state_reg;

    // -------------------------------------------------------------------------
    // Metadata FIFO, 2 x {runt, type}
    //
    // At the minimum depth the header commit and the head leaving the delay
    // line fall in the same cycle, so an empty FIFO forwards the entry being
    // pushed straight to the pop side.
    // -------------------------------------------------------------------------
    logic [16:0] fifo_mem [0:1];
    logic        fifo_wr_ptr_reg;
    logic        fifo_rd_ptr_reg;
    logic [1:0]  fifo_cnt_reg;
    logic        fifo_pop;
    logic        fifo_bypass;
    logic [16:0] push_entry;
    logic [16:0] pop_entry;
    logic        pop_runt;
    logic [15:0] pop_type;

    assign push_entry  = {push_runt, push_type};
    assign fifo_bypass = (fifo_cnt_reg == 2'd0) && fifo_push && fifo_pop;
    assign pop_entry   = (fifo_cnt_reg == 2'd0) ? push_entry : fifo_mem[fifo_rd_ptr_reg];
    assign pop_runt    = pop_entry[16];
    assign pop_type    = pop_entry[15:0];

    always_ff @(posedge i_clk) begin
        if (fifo_push && !fifo_bypass) begin
            fifo_mem[fifo_wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_cnt_reg    <= 2'd0;
        end else if (!fifo_bypass) begin
            if (fifo_push) begin
                fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
            end
            if (fifo_pop) begin
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_pop_not_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(fifo_pop && fifo_cnt_reg == 2'd0 && !fifo_push));
    a_push_not_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(fifo_push && !fifo_pop && fifo_cnt_reg == 2'd2));
`endif

    // -------------------------------------------------------------------------
    // Output stage
    // -------------------------------------------------------------------------
    out_state_t out_state_reg, out_state_next;
    logic       out_stray_reg, out_stray_next;
    logic       emit_wr;
    logic       load_type;
    logic       runt_inc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_state_reg <= OUT_IDLE_S;
            out_stray_reg <= 1'b0;
        end else begin
            out_state_reg <= out_state_next;
            out_stray_reg <= out_stray_next;
        end
    end

    always_comb begin
        out_state_next = out_state_reg;
        out_stray_next = out_stray_reg;
        fifo_pop       = 1'b0;
        emit_wr        = 1'b0;
        load_type      = 1'b0;
        runt_inc       = 1'b0;

        case (out_state_reg)
            OUT_IDLE_S: begin
                if (tap_wr) begin
                    if (tap_data[8]) begin
                        if (out_stray_reg) begin
                            out_stray_next = 1'b0;
                        end else begin
                            fifo_pop = 1'b1;
                            if (pop_runt) begin
                                runt_inc       = 1'b1;
                                out_state_next = OUT_DROP_S;
                            end else begin
                                emit_wr        = 1'b1;
                                load_type      = 1'b1;
                                out_state_next = OUT_PASS_S;
                            end
                        end
                    end else begin
                        out_stray_next = 1'b1;
                    end
                end
            end

            OUT_PASS_S: begin
                if (!tap_wr) begin
                    out_state_next = OUT_IDLE_S;
                end else begin
                    emit_wr = 1'b1;
                    if (tap_data[8]) begin
                        out_state_next = OUT_IDLE_S;
                    end
                end
            end

            OUT_DROP_S: begin
                if (!tap_wr || tap_data[8]) begin
                    out_state_next = OUT_IDLE_S;
                end
            end

            default: begin
                out_state_next = OUT_IDLE_S;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_data                   <= 9'd0;
            o_data_wr                 <= 1'b0;
            ov_eth_type               <= 16'h0000;
            o_standardpkt_tsnpkt_flag <= 1'b0;
            ov_runt_discard_cnt       <= 32'd0;
        end else begin
            ov_data   <= emit_wr ? tap_data : 9'd0;
            o_data_wr <= emit_wr;
            if (load_type) begin
                ov_eth_type               <= pop_type;
                o_standardpkt_tsnpkt_flag <= (pop_type != TSN_ETH_TYPE);
            end
            if (runt_inc) begin
                ov_runt_discard_cnt <= ov_runt_discard_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_type_extract.sv
// -----------------------------------------------------------------------------
// tb_eth_type_extract
//
// Builds the whole input stream frame by frame ahead of time. Each frame is
// generated with a known fate (kept, runt, truncated in header, truncated in
// body, VLAN tagged), so the expected output stream, EtherType, flag and
// discard count follow directly from how the frame was built plus the fixed
// latency. Resets in the stream cancel anything still in flight.
// -----------------------------------------------------------------------------
module tb_eth_type_extract;

`ifdef ETH_TYPE_VLAN_EN
    localparam int D = 18;
`else
    localparam int D = 14;
`endif
    localparam int MAXN = 12000;

    localparam int K_VALID      = 0;
    localparam int K_RUNT       = 1;
    localparam int K_TRUNC_HDR  = 2;
    localparam int K_TRUNC_BODY = 3;
    localparam int K_VLAN       = 4;

    logic        clk;
    logic        rst_n;
    logic [8:0]  data;
    logic        data_wr;
    logic [8:0]  ov_data;
    logic        o_data_wr;
    logic [15:0] ov_eth_type;
    logic        o_flag;
    logic [31:0] ov_cnt;
    logic [1:0]  ov_in_state;

    eth_type_extract #(
        .DELAY_CYCLES (14),
        .TSN_ETH_TYPE (16'h1800)
    ) dut (
        .i_clk                     (clk),
        .i_rst_n                   (rst_n),
        .iv_data                   (data),
        .i_data_wr                 (data_wr),
        .ov_data                   (ov_data),
        .o_data_wr                 (o_data_wr),
        .ov_eth_type               (ov_eth_type),
        .o_standardpkt_tsnpkt_flag (o_flag),
        .ov_runt_discard_cnt       (ov_cnt),
        .ov_in_state               (ov_in_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // input stream
    bit        in_wr  [MAXN];
    bit [8:0]  in_dat [MAXN];
    bit        in_rst [MAXN];   // value of rst_n during the cycle
    // per-input-cycle frame facts
    bit        em     [MAXN];   // byte should reach the output
    bit [1:0]  hk     [MAXN];   // head: 1 = kept frame, 2 = discarded frame
    bit [15:0] ht     [MAXN];
    // expected per output cycle
    bit        xw     [MAXN];
    bit [8:0]  xd     [MAXN];
    bit [1:0]  ek     [MAXN];
    bit [15:0] et     [MAXN];
    bit [15:0] xt     [MAXN];
    bit        xf     [MAXN];
    bit [31:0] xc     [MAXN];

    int n;
    int cyc;
    int n_checks;
    int n_errors;
    int n_frames;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic put(input bit w, input bit [8:0] d, input bit r);
        in_wr[n]  = w;
        in_dat[n] = w ? d : 9'd0;
        in_rst[n] = r;
        n++;
    endtask

    task automatic idle(input int cycles);
        for (int j = 0; j < cycles; j++) put(1'b0, 9'd0, 1'b1);
    endtask

    // cut >= 0: reset is asserted for 3 cycles in place of byte 'cut'
    task automatic send_frame(input int kind, input int len, input bit [15:0] typ,
                              input int gap_at, input int gap_len, input int cut,
                              input int gap_after);
        bit       kept;
        bit [7:0] b;
        kept = (kind == K_VALID) || (kind == K_TRUNC_BODY) || (kind == K_VLAN && len >= 18);
        n_frames++;
        $display("frame %0d: cycle=%0d kind=%0d len=%0d type=%h gap_at=%0d gap_len=%0d cut=%0d kept=%0d",
                 n_frames, n, kind, len, typ, gap_at, gap_len, cut, kept);
        for (int i = 0; i < len; i++) begin
            if (cut >= 0 && i == cut) begin
                for (int j = 0; j < 3; j++) put(1'b0, 9'd0, 1'b0);
                break;
            end
            if ((kind == K_TRUNC_HDR || kind == K_TRUNC_BODY) && i == gap_at) idle(gap_len);
            b = 8'($urandom_range(0, 255));
            if (kind == K_VLAN) begin
                if (i == 12) b = 8'h81;
                if (i == 13) b = 8'h00;
                if (i == 16) b = typ[15:8];
                if (i == 17) b = typ[7:0];
            end else begin
                if (i == 12) b = typ[15:8];
                if (i == 13) b = typ[7:0];
            end
            put(1'b1, {(i == 0 || i == len - 1), b}, 1'b1);
            em[n-1] = kept && !(kind == K_TRUNC_BODY && i >= gap_at);
            if (i == 0) begin
                hk[n-1] = kept ? 2'd1 : 2'd2;
                ht[n-1] = typ;
            end
        end
        idle(gap_after);
    endtask

    function automatic bit [15:0] rand_type();
        bit [15:0] t;
        t = ($urandom_range(0, 2) == 0) ? 16'h1800 : 16'($urandom_range(0, 65535));
        if (t == 16'h8100) t = 16'h8101;
        return t;
    endfunction

    task automatic build_expected();
        bit        alive;
        bit [15:0] ct;
        bit        cf;
        bit [31:0] cc;
        for (int c = 0; c < n; c++) begin
            alive = in_rst[c];
            for (int x = c + 1; x <= c + D; x++) begin
                if (x < n && !in_rst[x]) alive = 1'b0;
            end
            if (alive && c + D < n) begin
                if (em[c]) begin
                    xw[c+D] = 1'b1;
                    xd[c+D] = in_dat[c];
                end
                if (hk[c] != 2'd0) begin
                    ek[c+D] = hk[c];
                    et[c+D] = ht[c];
                end
            end
        end
        ct = 16'h0; cf = 1'b0; cc = 32'd0;
        for (int k = 0; k < n; k++) begin
            if (!in_rst[k]) begin
                ct = 16'h0; cf = 1'b0; cc = 32'd0;
            end else if (ek[k] == 2'd1) begin
                ct = et[k];
                cf = (et[k] != 16'h1800);
            end else if (ek[k] == 2'd2) begin
                cc = cc + 32'd1;
            end
            xt[k] = ct;
            xf[k] = cf;
            xc[k] = cc;
        end
    endtask

    initial begin
        int kind, len, ga, gl;
        rst_n    = 1'b0;
        data     = 9'd0;
        data_wr  = 1'b0;
        n        = 0;
        n_checks = 0;
        n_errors = 0;
        n_frames = 0;

        for (int j = 0; j < 3; j++) put(1'b0, 9'd0, 1'b0);
        idle(2);

        // directed cases
        send_frame(K_VALID, 64, 16'h1800, 0, 0, -1, 3);
        send_frame(K_VALID, 60, 16'h88f7, 0, 0, -1, 0);
        send_frame(K_VALID, 60, 16'hff01, 0, 0, -1, 2);
        send_frame(K_RUNT,  10, 16'h1234, 0, 0, -1, 0);
        send_frame(K_VALID, 60, 16'h1800, 0, 0, -1, 2);
        send_frame(K_TRUNC_HDR, 40, 16'h1800, 8, 3, -1, 2);
        send_frame(K_VALID, 14, 16'h0800, 0, 0, -1, 0);
        send_frame(K_RUNT,  13, 16'h0800, 0, 0, -1, 0);
        send_frame(K_TRUNC_HDR, 30, 16'h1800, 13, 1, -1, 0);
        send_frame(K_TRUNC_BODY, 40, 16'h86dd, 14, 2, -1, 1);
        send_frame(K_VALID, 100, 16'h0806, 0, 0, 20, 2);
        send_frame(K_VALID, 64, 16'h1800, 0, 0, -1, 3);
`ifdef ETH_TYPE_VLAN_EN
        send_frame(K_VLAN, 64, 16'h1800, 0, 0, -1, 0);
        send_frame(K_VLAN, 17, 16'h0800, 0, 0, -1, 1);
        send_frame(K_VLAN, 18, 16'h88f7, 0, 0, -1, 2);
`endif

        // randomized frames
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                send_frame(K_VALID, $urandom_range(14, 80), rand_type(), 0, 0, -1, $urandom_range(0, 3));
            end else if (kind == 6) begin
                send_frame(K_RUNT, $urandom_range(8, 13), rand_type(), 0, 0, -1, $urandom_range(0, 3));
            end else if (kind == 7) begin
                len = $urandom_range(20, 50);
                ga  = $urandom_range(1, 13);
                gl  = $urandom_range(1, 4);
                send_frame(K_TRUNC_HDR, len, rand_type(), ga, gl, -1, $urandom_range(0, 3));
            end else if (kind == 8) begin
                len = $urandom_range(24, 60);
                ga  = $urandom_range(14, len - 3);
                gl  = $urandom_range(1, 4);
                send_frame(K_TRUNC_BODY, len, rand_type(), ga, gl, -1, $urandom_range(0, 3));
            end else begin
`ifdef ETH_TYPE_VLAN_EN
                send_frame(K_VLAN, $urandom_range(14, 70), rand_type(), 0, 0, -1, $urandom_range(0, 3));
`else
                send_frame(K_VALID, $urandom_range(14, 80), 16'h1800, 0, 0, -1, $urandom_range(0, 3));
`endif
            end
        end
        idle(D + 4);

        build_expected();

        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst_n   = in_rst[k];
            data_wr = in_wr[k];
            data    = in_dat[k];
            #1;
            cyc = k;
            check("data_wr",  32'(o_data_wr),   32'(xw[k]));
            check("data",     32'(ov_data),     32'(xd[k]));
            check("eth_type", 32'(ov_eth_type), 32'(xt[k]));
            check("flag",     32'(o_flag),      32'(xf[k]));
            check("runt_cnt", ov_cnt,           xc[k]);
            if (!in_rst[k]) check("in_state_rst", 32'(ov_in_state), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_type_extract.md
Name: eth_type_extract

Overview:
- Upstream neighbour of the TSN NIC descriptor generator in the network input process.
- Takes the 9-bit per-port byte stream (bit8 marks both head and tail) and delays it by a fixed pipeline.
- Captures the EtherType at bytes 12–13, so the EtherType and the standard/TSN flag are stable when the head byte leaves the block.
- Drops runt/truncated frames before they reach descriptor extraction.

Parameters:
- DELAY_CYCLES, 14, pipeline depth in cycles from input byte to output byte; must be ≥ 14 (18 when ETH_TYPE_VLAN_EN is defined).
- TSN_ETH_TYPE, 16'h1800, EtherType identifying mapped TSN frames.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- iv_data  in  9  byte stream; [8]=1 on head and tail bytes, [7:0]=payload byte
- i_data_wr  in  1  byte valid; contiguous within a frame
- ov_data  out  9  delayed byte stream
- o_data_wr  out  1  delayed byte valid
- ov_eth_type  out  16  EtherType of the frame currently on the output
- o_standardpkt_tsnpkt_flag  out  1  1=standard Ethernet (eth_type≠TSN_ETH_TYPE), 0=TSN mapped
- ov_runt_discard_cnt  out  32  count of dropped runt/truncated frames
- ov_in_state  out  2  input capture FSM state, for debug

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk. On reset, all outputs go to 0, the delay line clears to wr=0/data=0, the metadata FIFO empties, and the FSM goes to IDLE_S.
- Reset mid-frame: the partial frame is lost entirely; no bytes of it reach the output.
- Delay line: DELAY_CYCLES stages of {wr, data[8:0]}. An input accepted in cycle t appears on ov_data/o_data_wr in cycle t+DELAY_CYCLES. Gaps (wr=0) are preserved.
- Input FSM (ov_in_state):
  - IDLE_S=0: wr & data[8] is a head. Clear byte_cnt to 1 and go to HDR_S. A wr byte without data[8] in IDLE_S is a stray; it passes into the delay line but is suppressed at the output.
  - HDR_S=1: byte_cnt increments per wr byte.
    - Byte index 12: latch type[15:8].
    - Byte index 13: latch type[7:0], push {runt=0, type} into the metadata FIFO, go to BODY_S.
    - Tail (wr & data[8]) or wr=0 before index 13: push {runt=1, 16'h0}, go to IDLE_S.
  - BODY_S=2: a tail or a wr=0 gap goes to IDLE_S. A frame committed after byte 13 passes through even if truncated.
- Metadata FIFO: 2 entries of {runt, type[15:0]}.
  - A push occurs no later than input cycle 13 after the head; the pop occurs when the head leaves the delay line (cycle DELAY_CYCLES). The entry is therefore always present at pop.
  - A pop on an empty FIFO is a design error; simulation asserts on it.
  - Simultaneous push and pop are allowed; the count is unchanged.
- Output stage, when the head emerges (delayed wr & data[8], output FSM idle):
  - Pop the FIFO.
  - If runt=0: drive the head byte. ov_eth_type <= type; o_standardpkt_tsnpkt_flag <= (type != TSN_ETH_TYPE). Hold both until the next head is emitted.
  - If runt=1: suppress o_data_wr and zero ov_data up to and including the delayed tail, or the first delayed gap. Increment ov_runt_discard_cnt by 1; it wraps at 2^32.
  - Bytes after a delayed gap and before the next delayed head are suppressed.
- Throughput: one byte per cycle. Back-to-back frames (a head in the cycle after a tail) are supported with no added bubble.

Optional Feature:
- Macro: ETH_TYPE_VLAN_EN.
- Defined:
  - Effective depth is 18.
  - If bytes 12–13 = 16'h8100, bytes 16–17 are latched as the EtherType and the push moves to index 17.
  - A frame ending before index 17 is a runt.
  - The TSN/standard flag uses the inner type.
- Undefined: the EtherType always comes from bytes 12–13; depth is DELAY_CYCLES.

Test Plan:
- 64-byte frame, bytes 12–13 = 18 00, contiguous. Required: identical bytes on output exactly 14 cycles later; ov_eth_type=16'h1800 and flag=0 from the head output cycle; cnt=0.
- Frame with type 88 F7, immediately followed by a frame with type FF 01, zero-gap. Required: output contiguous; ov_eth_type changes 16'h88f7→16'hff01 exactly on the second head output; flag=1 for both.
- 10-byte runt (tail at index 9), then a valid 60-byte 0x1800 frame. Required: no output wr for the runt; cnt=1; second frame output intact with eth_type=16'h1800.
- 40-byte frame with wr dropped at index 8 and resumed at index 11. Required: treated as truncated; all of its bytes are suppressed; cnt=1.
- Reset asserted at input byte 20 of a 100-byte frame, released 3 cycles later, then a new valid frame. Required: outputs 0 during reset; no residual bytes from the old frame; new frame correct.
- With ETH_TYPE_VLAN_EN: frame with 81 00 at 12–13 and 18 00 at 16–17. Required: latency 18; ov_eth_type=16'h1800; flag=0.
